writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- MEM/WB pipeline register and write-back formatter for the pipelined MIPS core.
- Captures the memory-stage result bundle and extends load data for byte/halfword loads.
- Selects the write-back source (ALU, memory, link PC+8) and drives the register file write port (writeRegNumber, writeData, regWriteSignal).
- Also counts retired instructions and flags misaligned loads.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- REG_ADDR_WIDTH, 5, register number width.
- COUNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- inValid  in  1  MEM stage holds a real instruction.
- stall  in  1  hold MEM/WB contents this cycle.
- flush  in  1  squash the incoming instruction.
- regWrite  in  1  instruction writes a register.
- memToReg  in  1  result comes from memory.
- linkSignal  in  1  result is pcPlus8 (jal/jalr); has priority over memToReg.
- loadType  in  3  0=LW, 1=LB, 2=LBU, 3=LH, 4=LHU; 5-7 are treated as LW.
- aluResult  in  32  ALU result / load address.
- memReadData  in  32  aligned word read from data memory.
- pcPlus8  in  32  link value.
- destRegNumber  in  5  destination register.
- writeRegNumber  out  5  register file write address.
- writeData  out  32  register file write data.
- regWriteSignal  out  1  register file write enable.
- wbValid  out  1  WB stage holds a valid instruction.
- retiredCount  out  COUNT_WIDTH  instructions retired.
- misalignFault  out  1  sticky misaligned-load flag.

Behaviour:
- Reset (synchronous): all outputs are 0, including wbValid, regWriteSignal, writeData, writeRegNumber, retiredCount and misalignFault; the internal committed flag is cleared. Reset overrides stall and flush.
- Capture: on posedge with !stall, the stage loads the formatted result.
  - wbValid <= inValid & !flush.
  - Outputs change one cycle after the inputs are sampled (latency 1).
- Flush with !stall: wbValid <= 0 and regWriteSignal <= 0. The data fields may load but are don't-care.
- Stall: all stage registers hold. The write is committed exactly once:
  - regWriteSignal is high only in the first cycle the entry is present.
  - During held cycles regWriteSignal is 0; writeRegNumber and writeData keep their values.
- regWriteSignal = wbValid & regWrite & (destRegNumber != 0) & first cycle of the entry. A write to r0 is never issued, even if regWrite is set.
- Source select: linkSignal ? pcPlus8 : memToReg ? extendedLoad : aluResult.
- Load extension uses offset = aluResult[1:0], little-endian lane select.
  - LB: sign-extend byte[offset]. LBU: zero-extend byte[offset].
  - LH / LHU: lane = offset[1]; sign- or zero-extend respectively.
  - LW: the word is passed through unchanged.
- Misalignment applies only to valid, unflushed memToReg loads:
  - LH/LHU with offset[0]=1, or LW with offset != 0, sets misalignFault (sticky until reset).
  - The write is still performed using the aligned lane (offset[0] or offset[1:0] ignored).
- retiredCount increments by 1 on each cycle in which a new valid entry is captured (one per instruction, not per stall cycle). It wraps modulo 2^COUNT_WIDTH.
- Simultaneous stall and flush: stall wins and the stage holds; the flush is the hazard unit's responsibility to re-present.
- Timing vs. register file: writeData and regWriteSignal are stable before the posedge on which the register file samples them. No combinational path exists from inputs to outputs.

Decomposition:
- Shared package / header `mips_defs`: the loadType encodings (LOAD_LW, LOAD_LB, LOAD_LBU, LOAD_LH, LOAD_LHU) and the DATA_WIDTH / REG_ADDR_WIDTH constants. These are shared with the decoder and the memory stage.
- One combinational sub-module, `load_extender` (inputs: word, offset, loadType; outputs: result, misaligned). It is reused by any future load-forwarding path.

Test Plan:
- Reset mid-operation: hold reset for 2 cycles while inValid=1, regWrite=1, destRegNumber=5 → all outputs 0 and retiredCount=0. The first capture after reset gives writeRegNumber=5 and regWriteSignal=1.
- ALU write followed by an r0 write:
  - aluResult=0x00000064, dest=3 → next cycle writeData=0x64, writeRegNumber=3, regWriteSignal=1.
  - Same with dest=0 → regWriteSignal=0, while retiredCount still increments.
- Load extension with memReadData=0x80FF7F01:
  - LB offset=1 → 0x0000007F.
  - LB offset=3 → 0xFFFFFF80.
  - LBU offset=2 → 0x000000FF.
  - LH offset=2 → 0xFFFF80FF.
  - LHU offset=0 → 0x00007F01.
- Stall for 3 cycles holding a write of 0x1234 to r7 → regWriteSignal=1 for exactly one cycle, writeData stays 0x1234, and retiredCount increases by exactly 1.
- Flush with inValid=1, regWrite=1 → wbValid=0, regWriteSignal=0, no count. Stall and flush together → the stage holds its previous entry.
- Link and fault cases:
  - linkSignal=1 with memToReg=1, pcPlus8=0x00400018, dest=31 → writeData=0x00400018.
  - LW with aluResult=0x1002 → misalignFault=1, and it stays 1 until reset.

Source files
------------

// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
// Module      : mips_defs
// Description : Datapath widths and load-type encodings shared by the decoder,
//               memory stage and write-back stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [2:0] LOAD_LW  = 3'd0;
    localparam logic [2:0] LOAD_LB  = 3'd1;
    localparam logic [2:0] LOAD_LBU = 3'd2;
    localparam logic [2:0] LOAD_LH  = 3'd3;
    localparam logic [2:0] LOAD_LHU = 3'd4;

endpackage
`default_nettype wire

// File: rtl/load_extender.sv
`default_nettype none
// ============================================================================
// Module      : load_extender
// Description : Little-endian lane select and sign/zero extension of a loaded
//               word, with misalignment detection for halfword/word loads.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extender
    import mips_defs::*;
(
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            offset,
    input  logic [2:0]            loadType,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (offset)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        // Halfword lane ignores offset[0] so a misaligned access still reads the aligned lane
        w_half = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result     = word;
        misaligned = 1'b0;
        case (loadType)
            LOAD_LB:  result = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            LOAD_LBU: result = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            LOAD_LH: begin
                result     = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
                misaligned = offset[0];
            end
            LOAD_LHU: begin
                result     = {{(DATA_WIDTH-16){1'b0}}, w_half};
                misaligned = offset[0];
            end
            default:  misaligned = (offset != 2'b00);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : MEM/WB pipeline register and write-back formatter; drives the
//               register file write port, counts retirements, flags misaligned loads.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inValid,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      regWrite,
    input  logic                      memToReg,
    input  logic                      linkSignal,
    input  logic [2:0]                loadType,
    input  logic [DATA_WIDTH-1:0]     aluResult,
    input  logic [DATA_WIDTH-1:0]     memReadData,
    input  logic [DATA_WIDTH-1:0]     pcPlus8,
    input  logic [REG_ADDR_WIDTH-1:0] destRegNumber,
    output logic [REG_ADDR_WIDTH-1:0] writeRegNumber,
    output logic [DATA_WIDTH-1:0]     writeData,
    output logic                      regWriteSignal,
    output logic                      wbValid,
    output logic [COUNT_WIDTH-1:0]    retiredCount,
    output logic                      misalignFault
);

    import mips_defs::*;

    logic [DATA_WIDTH-1:0]     w_extendedLoad;
    logic                      w_misaligned;
    logic                      w_enter;
    logic [DATA_WIDTH-1:0]     w_source;

    logic [REG_ADDR_WIDTH-1:0] r_writeRegNumber;
    logic [DATA_WIDTH-1:0]     r_writeData;
    logic                      r_regWriteSignal;
    logic                      r_wbValid;
    logic [COUNT_WIDTH-1:0]    r_retiredCount;
    logic                      r_misalignFault;

    load_extender u_loadExtender (
        .word       (memReadData),
        .offset     (aluResult[1:0]),
        .loadType   (loadType),
        .result     (w_extendedLoad),
        .misaligned (w_misaligned)
    );

    assign w_enter  = inValid & ~flush;
    assign w_source = linkSignal ? pcPlus8 : (memToReg ? w_extendedLoad : aluResult);

    // r_regWriteSignal doubles as the committed flag: it is set only on the
    // capture cycle and cleared on every held cycle, so a stalled entry writes once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_writeRegNumber <= '0;
            r_writeData      <= '0;
            r_regWriteSignal <= 1'b0;
            r_wbValid        <= 1'b0;
            r_retiredCount   <= '0;
            r_misalignFault  <= 1'b0;
        end else if (!stall) begin
            r_wbValid        <= w_enter;
            r_regWriteSignal <= w_enter & regWrite & (destRegNumber != '0);
            r_writeRegNumber <= destRegNumber;
            r_writeData      <= w_source;
            if (w_enter) begin
                r_retiredCount <= r_retiredCount + COUNT_WIDTH'(1);
            end
            if (w_enter && memToReg && w_misaligned) begin
                r_misalignFault <= 1'b1;
            end
        end else begin
            r_regWriteSignal <= 1'b0;
        end
    end

    assign writeRegNumber = r_writeRegNumber;
    assign writeData      = r_writeData;
    assign regWriteSignal = r_regWriteSignal;
    assign wbValid        = r_wbValid;
    assign retiredCount   = r_retiredCount;
    assign misalignFault  = r_misalignFault;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Directed and randomized bench for writeback_stage against a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid, stall, flush, regWrite, memToReg, linkSignal;
    logic [2:0]  loadType;
    logic [31:0] aluResult, memReadData, pcPlus8;
    logic [4:0]  destRegNumber;
    logic [4:0]  writeRegNumber;
    logic [31:0] writeData;
    logic        regWriteSignal, wbValid, misalignFault;
    logic [31:0] retiredCount;

    int passes = 0;
    int total  = 0;

    // reference model state
    logic        mValid, mWen, mFault;
    logic [4:0]  mReg;
    logic [31:0] mData, mCount;

    always #5 clk = ~clk;

    writeback_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .COUNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .stall(stall), .flush(flush),
        .regWrite(regWrite), .memToReg(memToReg), .linkSignal(linkSignal),
        .loadType(loadType), .aluResult(aluResult), .memReadData(memReadData),
        .pcPlus8(pcPlus8), .destRegNumber(destRegNumber),
        .writeRegNumber(writeRegNumber), .writeData(writeData),
        .regWriteSignal(regWriteSignal), .wbValid(wbValid),
        .retiredCount(retiredCount), .misalignFault(misalignFault)
    );

    function automatic logic [31:0] refExtend(input logic [2:0] lt, input logic [31:0] mem,
                                              input int unsigned off);
        int unsigned b, h;
        b = (mem >> (off * 8)) & 32'hFF;
        h = (mem >> ((off / 2) * 16)) & 32'hFFFF;
        case (lt)
            3'd1:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return mem;
        endcase
    endfunction

    function automatic bit refMisaligned(input logic [2:0] lt, input int unsigned off);
        if (lt == 3'd1 || lt == 3'd2) return 1'b0;
        if (lt == 3'd3 || lt == 3'd4) return (off % 2) != 0;
        return off != 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic compareAll(input string tag);
        chk({tag, ".wbValid"},        {31'b0, wbValid},        {31'b0, mValid});
        chk({tag, ".regWriteSignal"}, {31'b0, regWriteSignal}, {31'b0, mWen});
        chk({tag, ".retiredCount"},   retiredCount,            mCount);
        chk({tag, ".misalignFault"},  {31'b0, misalignFault},  {31'b0, mFault});
        if (mValid) begin
            chk({tag, ".writeData"},      writeData,             mData);
            chk({tag, ".writeRegNumber"}, {27'b0, writeRegNumber}, {27'b0, mReg});
        end
    endtask

    // Model one clock edge from the currently driven inputs
    task automatic modelEdge();
        int unsigned off;
        logic enter;
        off = aluResult & 32'h3;
        if (reset) begin
            mValid = 0; mWen = 0; mFault = 0; mReg = 0; mData = 0; mCount = 0;
        end else if (stall) begin
            mWen = 0;
        end else begin
            enter  = inValid && !flush;
            mValid = enter;
            mWen   = enter && regWrite && destRegNumber != 0;
            mReg   = destRegNumber;
            if (linkSignal)    mData = pcPlus8;
            else if (memToReg) mData = refExtend(loadType, memReadData, off);
            else               mData = aluResult;
            if (enter) mCount = mCount + 1;
            if (enter && memToReg && refMisaligned(loadType, off)) mFault = 1;
        end
    endtask

    task automatic step(input string tag, input logic v, input logic st, input logic fl,
                        input logic rw, input logic m2r, input logic lnk, input logic [2:0] lt,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc8,
                        input logic [4:0] dest);
        inValid = v; stall = st; flush = fl; regWrite = rw; memToReg = m2r;
        linkSignal = lnk; loadType = lt; aluResult = alu; memReadData = mem;
        pcPlus8 = pc8; destRegNumber = dest;
        modelEdge();
        @(posedge clk);
        #1;
        compareAll(tag);
    endtask

    initial begin
        logic [31:0] cnt0;
        logic [31:0] ld;
        ld = 32'h80FF_7F01;

        // reset held 2 cycles with an active write presented
        reset = 1; inValid = 1; stall = 0; flush = 0; regWrite = 1; memToReg = 0;
        linkSignal = 0; loadType = 0; aluResult = 32'h55; memReadData = 0; pcPlus8 = 0;
        destRegNumber = 5;
        repeat (2) begin modelEdge(); @(posedge clk); #1; end
        compareAll("reset");
        chk("reset.writeData", writeData, 32'h0);
        chk("reset.writeRegNumber", {27'b0, writeRegNumber}, 32'h0);
        reset = 0;
        step("post_reset", 1, 0, 0, 1, 0, 0, 0, 32'h55, 0, 0, 5);
        chk("post_reset.reg", {27'b0, writeRegNumber}, 32'd5);
        chk("post_reset.wen", {31'b0, regWriteSignal}, 32'd1);

        step("alu_r3", 1, 0, 0, 1, 0, 0, 0, 32'h64, 0, 0, 3);
        chk("alu_r3.data", writeData, 32'h64);
        cnt0 = retiredCount;
        step("alu_r0", 1, 0, 0, 1, 0, 0, 0, 32'h64, 0, 0, 0);
        chk("alu_r0.wen", {31'b0, regWriteSignal}, 32'd0);
        chk("alu_r0.count", retiredCount, cnt0 + 1);

        step("lb1", 1, 0, 0, 1, 1, 0, 3'd1, 32'h1001, ld, 0, 8);
        chk("lb1.data", writeData, 32'h0000_007F);
        step("lb3", 1, 0, 0, 1, 1, 0, 3'd1, 32'h1003, ld, 0, 8);
        chk("lb3.data", writeData, 32'hFFFF_FF80);
        step("lbu2", 1, 0, 0, 1, 1, 0, 3'd2, 32'h1002, ld, 0, 8);
        chk("lbu2.data", writeData, 32'h0000_00FF);
        step("lh2", 1, 0, 0, 1, 1, 0, 3'd3, 32'h1002, ld, 0, 8);
        chk("lh2.data", writeData, 32'hFFFF_80FF);
        step("lhu0", 1, 0, 0, 1, 1, 0, 3'd4, 32'h1000, ld, 0, 8);
        chk("lhu0.data", writeData, 32'h0000_7F01);
        chk("lhu0.nofault", {31'b0, misalignFault}, 32'd0);

        // one write held through 3 stall cycles commits exactly once
        cnt0 = retiredCount;
        step("stall_cap", 1, 0, 0, 1, 0, 0, 0, 32'h1234, 0, 0, 7);
        for (int i = 0; i < 3; i++)
            step("stall_hold", 1, 1, 0, 1, 0, 0, 0, 32'hDEAD, 0, 0, 9);
        chk("stall.data", writeData, 32'h1234);
        chk("stall.count", retiredCount, cnt0 + 1);

        cnt0 = retiredCount;
        step("flush", 1, 0, 1, 1, 0, 0, 0, 32'h77, 0, 0, 4);
        chk("flush.valid", {31'b0, wbValid}, 32'd0);
        chk("flush.count", retiredCount, cnt0);
        step("pre_sf", 1, 0, 0, 1, 0, 0, 0, 32'hABCD, 0, 0, 12);
        step("stall_flush", 1, 1, 1, 1, 0, 0, 0, 32'h9999, 0, 0, 13);
        chk("stall_flush.data", writeData, 32'hABCD);
        chk("stall_flush.valid", {31'b0, wbValid}, 32'd1);

        step("link", 1, 0, 0, 1, 1, 1, 3'd0, 32'h1000, ld, 32'h0040_0018, 31);
        chk("link.data", writeData, 32'h0040_0018);

        step("lw_mis", 1, 0, 0, 1, 1, 0, 3'd0, 32'h1002, ld, 0, 6);
        chk("lw_mis.fault", {31'b0, misalignFault}, 32'd1);
        chk("lw_mis.data", writeData, ld);
        step("sticky1", 1, 0, 0, 1, 0, 0, 0, 32'h1, 0, 0, 2);
        step("sticky2", 0, 0, 0, 0, 0, 0, 0, 32'h2, 0, 0, 2);
        chk("sticky.fault", {31'b0, misalignFault}, 32'd1);
        reset = 1;
        step("reset2", 1, 0, 0, 1, 0, 0, 0, 32'h3, 0, 0, 2);
        chk("reset2.fault", {31'b0, misalignFault}, 32'd0);
        reset = 0;

        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 9) < 8), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 6) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, ($urandom_range(0, 7) == 0),
                 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                 5'($urandom_range(0, 31)));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
`default_nettype wire
